// File: rtl/image_sprite_anim.sv
`default_nettype none
// ============================================================================
// Module      : image_sprite_anim
// Description : Multi-frame palette-indexed sprite renderer with integer
//               upscaling, colour-key transparency and an animation sequencer.
//               The pixel path has a fixed 4-cycle latency from
//               hcount_in/vcount_in to RGB:
//                 image BROM (2 cycles) -> palette BROM (2 cycles)
//               ROM contents are generated by constant functions, so the
//               block needs no external memory initialisation files.
// Ports       : pixel_clk_in     pixel clock
//               rst_in           asynchronous active-low reset
//               x_in, y_in       sprite top-left on screen
//               hcount_in        current pixel column
//               vcount_in        current pixel row
//               frame_tick_in    one pulse per video frame
//               start_in         latch mode_in/frame_sel_in, start sequence
//               mode_in          0 HOLD, 1 LOOP, 2 ONESHOT, 3 PINGPONG
//               frame_sel_in     start frame (displayed frame in HOLD)
//               red/green/blue_out  pixel colour, 0 when no opaque pixel
//               pixel_valid_out  opaque sprite pixel present
//               frame_out        frame currently displayed
//               busy_out         sequencer running
// Revision    : 1.0 - initial release
// ============================================================================
module image_sprite_anim #(
  parameter int WIDTH           = 256,
  parameter int HEIGHT          = 256,
  parameter int NUM_FRAMES      = 4,
  parameter int SCALE_LOG2      = 0,
  parameter int TICKS_PER_FRAME = 8,
  parameter int TRANSPARENT_KEY = 0,
  localparam int c_FRAME_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                 pixel_clk_in,
  input  logic                 rst_in,
  input  logic [10:0]          x_in,
  input  logic [9:0]           y_in,
  input  logic [10:0]          hcount_in,
  input  logic [9:0]           vcount_in,
  input  logic                 frame_tick_in,
  input  logic                 start_in,
  input  logic [1:0]           mode_in,
  input  logic [c_FRAME_W-1:0] frame_sel_in,
  output logic [7:0]           red_out,
  output logic [7:0]           green_out,
  output logic [7:0]           blue_out,
  output logic                 pixel_valid_out,
  output logic [c_FRAME_W-1:0] frame_out,
  output logic                 busy_out
);

  localparam int c_ADDR_W = $clog2(WIDTH * HEIGHT * NUM_FRAMES);
  localparam int c_CNT_W  = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

  localparam logic [12:0]          c_SPR_W    = 13'(WIDTH << SCALE_LOG2);
  localparam logic [12:0]          c_SPR_H    = 13'(HEIGHT << SCALE_LOG2);
  localparam logic [c_FRAME_W-1:0] c_LAST     = c_FRAME_W'(NUM_FRAMES - 1);
  localparam logic [c_FRAME_W-1:0] c_FR_ONE   = c_FRAME_W'(1);
  localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(TICKS_PER_FRAME - 1);
  localparam logic [c_CNT_W-1:0]   c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [7:0]           c_TKEY     = 8'(TRANSPARENT_KEY);

  localparam logic [1:0] c_MODE_HOLD     = 2'd0;
  localparam logic [1:0] c_MODE_LOOP     = 2'd1;
  localparam logic [1:0] c_MODE_ONESHOT  = 2'd2;
  localparam logic [1:0] c_MODE_PINGPONG = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Image ROM content: key depends on column, row and frame so every frame
  // differs and a few texels land on the transparent key.
  function automatic logic [7:0] image_key(input logic [c_ADDR_W-1:0] a);
    logic [31:0] w_a;
    w_a = 32'(a);
    return 8'(w_a + 32'd3 * (w_a >> 8) + 32'd37 * (w_a >> 16) + 32'd1);
  endfunction

  // Palette ROM content: 24-bit RGB per key.
  function automatic logic [23:0] palette_rgb(input logic [7:0] k);
    return {k, ~k, k[3:0], k[7:4]};
  endfunction

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_t               r_state;
  logic [c_FRAME_W-1:0] r_frame;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_dir_up;
  logic [1:0]           r_mode;
  logic                 r_busy;

  logic [c_FRAME_W-1:0] w_frame_inc;
  logic [c_FRAME_W-1:0] w_frame_dec;
  logic [c_FRAME_W-1:0] w_sel_clamped;

  assign w_frame_inc   = r_frame + c_FR_ONE;
  assign w_frame_dec   = r_frame - c_FR_ONE;
  assign w_sel_clamped = (32'(frame_sel_in) > 32'(NUM_FRAMES - 1)) ? c_LAST : frame_sel_in;

  // start_in has priority over frame_tick_in; ticks only count while running.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= ST_IDLE;
      r_frame  <= '0;
      r_cnt    <= '0;
      r_dir_up <= 1'b1;
      r_mode   <= c_MODE_HOLD;
      r_busy   <= 1'b0;
    end else if (start_in) begin
      r_state  <= ST_RUN;
      r_frame  <= w_sel_clamped;
      r_cnt    <= '0;
      r_dir_up <= 1'b1;
      r_mode   <= mode_in;
      r_busy   <= 1'b1;
    end else if (r_state == ST_RUN && frame_tick_in) begin
      if (r_cnt != c_CNT_LAST) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end else begin
        r_cnt <= '0;
        case (r_mode)
          c_MODE_LOOP: begin
            r_frame <= (r_frame == c_LAST) ? '0 : w_frame_inc;
          end
          c_MODE_ONESHOT: begin
            if (r_frame != c_LAST) begin
              r_frame <= w_frame_inc;
            end
            // Started on the last frame (or only one frame): finish at once.
            if (r_frame == c_LAST || w_frame_inc == c_LAST) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
            end
          end
          c_MODE_PINGPONG: begin
            if (c_LAST != '0) begin
              if (r_dir_up) begin
                // A start on the last frame bounces straight back down.
                if (r_frame == c_LAST) begin
                  r_frame  <= w_frame_dec;
                  r_dir_up <= 1'b0;
                end else begin
                  r_frame <= w_frame_inc;
                  if (w_frame_inc == c_LAST) begin
                    r_dir_up <= 1'b0;
                  end
                end
              end else begin
                if (r_frame == '0) begin
                  r_frame  <= w_frame_inc;
                  r_dir_up <= 1'b1;
                end else begin
                  r_frame <= w_frame_dec;
                  if (w_frame_dec == '0) begin
                    r_dir_up <= 1'b1;
                  end
                end
              end
            end
          end
          default: begin
            r_frame <= r_frame;
          end
        endcase
      end
    end
  end

  assign frame_out = r_frame;
  assign busy_out  = r_busy;

  // ---------------------------------------------------------------------------
  // Pixel path
  // ---------------------------------------------------------------------------
  // Offsets are widened by two bits so a pixel left of / above the sprite
  // shows up as a set MSB instead of wrapping into range.
  logic [12:0]         w_dx;
  logic [12:0]         w_dy;
  logic                w_in_sprite;
  logic [c_ADDR_W-1:0] w_addr;

  assign w_dx        = {2'b00, hcount_in} - {2'b00, x_in};
  assign w_dy        = {3'b000, vcount_in} - {3'b000, y_in};
  assign w_in_sprite = !w_dx[12] && !w_dy[12] && (w_dx < c_SPR_W) && (w_dy < c_SPR_H);
  assign w_addr      = c_ADDR_W'(32'(r_frame) * 32'(WIDTH * HEIGHT)
                                 + 32'(w_dy >> SCALE_LOG2) * 32'(WIDTH)
                                 + 32'(w_dx >> SCALE_LOG2));

  logic [7:0]  r_img_q1;
  logic [7:0]  r_key;
  logic [23:0] r_pal_q1;
  logic        r_opaque;
  logic [2:0]  r_vld;

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_img_q1        <= '0;
      r_key           <= '0;
      r_pal_q1        <= '0;
      r_opaque        <= 1'b0;
      r_vld           <= '0;
      red_out         <= '0;
      green_out       <= '0;
      blue_out        <= '0;
      pixel_valid_out <= 1'b0;
    end else begin
      // Stage 1-2: image BROM read and output register.
      r_img_q1 <= image_key(w_addr);
      r_key    <= r_img_q1;
      // Stage 3: palette BROM read; opacity decided alongside it.
      r_pal_q1 <= palette_rgb(r_key);
      r_opaque <= (r_key != c_TKEY);
      r_vld    <= {r_vld[1:0], w_in_sprite};
      // Stage 4: palette output register, gated to black when not visible.
      pixel_valid_out <= r_vld[2] && r_opaque;
      red_out         <= (r_vld[2] && r_opaque) ? r_pal_q1[23:16] : 8'd0;
      green_out       <= (r_vld[2] && r_opaque) ? r_pal_q1[15:8]  : 8'd0;
      blue_out        <= (r_vld[2] && r_opaque) ? r_pal_q1[7:0]   : 8'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_image_sprite_anim.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_image_sprite_anim
// Description : Self-checking bench for image_sprite_anim. Four instances with
//               different geometry/sequencer parameters share one stimulus;
//               a behavioural model predicts every output every cycle, and
//               directed literal checks pin the model to hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_sprite_anim;

  localparam int NI = 4;
  localparam int P_W  [NI] = '{256, 256, 64, 16};
  localparam int P_H  [NI] = '{256, 256, 32, 8};
  localparam int P_NF [NI] = '{4, 4, 5, 1};
  localparam int P_S  [NI] = '{0, 1, 0, 2};
  localparam int P_TPF[NI] = '{2, 1, 3, 1};
  localparam int P_TK [NI] = '{0, 0, 5, 0};
  localparam int P_FM [NI] = '{3, 3, 7, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hc, x;
  logic [9:0]  vc, y;
  logic        tick, start;
  logic [1:0]  mode;
  logic [2:0]  sel;

  logic [NI-1:0][7:0] red, grn, blu;
  logic [NI-1:0]      vld, bsy;
  logic [1:0]         fa, fb;
  logic [2:0]         fc;
  logic               fd;

  int n_cmp = 0;
  int n_bad = 0;
  bit scan  = 0;
  int scan_n = 0;

  always #5 clk = ~clk;

  image_sprite_anim #(.WIDTH(P_W[0]), .HEIGHT(P_H[0]), .NUM_FRAMES(P_NF[0]), .SCALE_LOG2(P_S[0]),
                      .TICKS_PER_FRAME(P_TPF[0]), .TRANSPARENT_KEY(P_TK[0])) u_a (
    .pixel_clk_in(clk), .rst_in(rst_n), .x_in(x), .y_in(y), .hcount_in(hc), .vcount_in(vc),
    .frame_tick_in(tick), .start_in(start), .mode_in(mode), .frame_sel_in(sel[1:0]),
    .red_out(red[0]), .green_out(grn[0]), .blue_out(blu[0]), .pixel_valid_out(vld[0]),
    .frame_out(fa), .busy_out(bsy[0]));

  image_sprite_anim #(.WIDTH(P_W[1]), .HEIGHT(P_H[1]), .NUM_FRAMES(P_NF[1]), .SCALE_LOG2(P_S[1]),
                      .TICKS_PER_FRAME(P_TPF[1]), .TRANSPARENT_KEY(P_TK[1])) u_b (
    .pixel_clk_in(clk), .rst_in(rst_n), .x_in(x), .y_in(y), .hcount_in(hc), .vcount_in(vc),
    .frame_tick_in(tick), .start_in(start), .mode_in(mode), .frame_sel_in(sel[1:0]),
    .red_out(red[1]), .green_out(grn[1]), .blue_out(blu[1]), .pixel_valid_out(vld[1]),
    .frame_out(fb), .busy_out(bsy[1]));

  image_sprite_anim #(.WIDTH(P_W[2]), .HEIGHT(P_H[2]), .NUM_FRAMES(P_NF[2]), .SCALE_LOG2(P_S[2]),
                      .TICKS_PER_FRAME(P_TPF[2]), .TRANSPARENT_KEY(P_TK[2])) u_c (
    .pixel_clk_in(clk), .rst_in(rst_n), .x_in(x), .y_in(y), .hcount_in(hc), .vcount_in(vc),
    .frame_tick_in(tick), .start_in(start), .mode_in(mode), .frame_sel_in(sel),
    .red_out(red[2]), .green_out(grn[2]), .blue_out(blu[2]), .pixel_valid_out(vld[2]),
    .frame_out(fc), .busy_out(bsy[2]));

  image_sprite_anim #(.WIDTH(P_W[3]), .HEIGHT(P_H[3]), .NUM_FRAMES(P_NF[3]), .SCALE_LOG2(P_S[3]),
                      .TICKS_PER_FRAME(P_TPF[3]), .TRANSPARENT_KEY(P_TK[3])) u_d (
    .pixel_clk_in(clk), .rst_in(rst_n), .x_in(x), .y_in(y), .hcount_in(hc), .vcount_in(vc),
    .frame_tick_in(tick), .start_in(start), .mode_in(mode), .frame_sel_in(sel[0]),
    .red_out(red[3]), .green_out(grn[3]), .blue_out(blu[3]), .pixel_valid_out(vld[3]),
    .frame_out(fd), .busy_out(bsy[3]));

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [10:0]          hc;
    logic [9:0]           vc;
    logic [10:0]          x;
    logic [9:0]           y;
    logic [NI-1:0][2:0]   fr;
  } hist_t;

  hist_t q[$];
  int    m_fr [NI];
  int    m_cnt[NI];
  int    m_st [NI];   // 0 idle, 1 running, 2 finished
  int    m_md [NI];
  bit    m_up [NI];

  // {valid, r, g, b} a pixel must show, straight from the geometry rules.
  function automatic logic [24:0] exp_pix(input int i, input hist_t h);
    int dx, dy, a, k, r, g, b;
    dx = int'(h.hc) - int'(h.x);
    dy = int'(h.vc) - int'(h.y);
    if (dx < 0 || dy < 0 || dx >= (P_W[i] << P_S[i]) || dy >= (P_H[i] << P_S[i])) return '0;
    a = int'(h.fr[i]) * P_W[i] * P_H[i] + (dy >> P_S[i]) * P_W[i] + (dx >> P_S[i]);
    k = (a + 3 * (a / 256) + 37 * (a / 65536) + 1) % 256;
    if (k == P_TK[i]) return '0;
    r = k;
    g = 255 - k;
    b = (k % 16) * 16 + k / 16;
    return {1'b1, 8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic seq_step(input int i);
    int s, nf;
    nf = P_NF[i];
    if (start) begin
      s        = int'(sel) & P_FM[i];
      m_fr[i]  = (s > nf - 1) ? nf - 1 : s;
      m_cnt[i] = 0;
      m_up[i]  = 1;
      m_md[i]  = int'(mode);
      m_st[i]  = 1;
    end else if (m_st[i] == 1 && tick) begin
      m_cnt[i]++;
      if (m_cnt[i] == P_TPF[i]) begin
        m_cnt[i] = 0;
        case (m_md[i])
          1: m_fr[i] = (m_fr[i] + 1) % nf;
          2: begin
            if (m_fr[i] < nf - 1) m_fr[i]++;
            if (m_fr[i] == nf - 1) m_st[i] = 2;
          end
          3: if (nf > 1) begin
            if ((m_up[i] && m_fr[i] < nf - 1) || (!m_up[i] && m_fr[i] == 0)) begin
              m_fr[i]++;
              m_up[i] = (m_fr[i] != nf - 1);
            end else begin
              m_fr[i]--;
              m_up[i] = (m_fr[i] == 0);
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [31:0] act_fr(input int i);
    case (i)
      0: return 32'(fa);
      1: return 32'(fb);
      2: return 32'(fc);
      default: return 32'(fd);
    endcase
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s u%0d @%0t: got %0h want %0h", nm, i, $time, got, want);
    end
  endtask

  always @(posedge clk) begin
    hist_t       h;
    logic [24:0] want;
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_fr[i] = 0; m_cnt[i] = 0; m_st[i] = 0; m_md[i] = 0; m_up[i] = 1;
      end
      q.delete();
    end else begin
      h.hc = hc; h.vc = vc; h.x = x; h.y = y;
      for (int i = 0; i < NI; i++) h.fr[i] = 3'(m_fr[i]);
      q.push_back(h);
      if (q.size() > 4) void'(q.pop_front());
      for (int i = 0; i < NI; i++) seq_step(i);
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      want = (q.size() == 4) ? exp_pix(i, q[0]) : 25'd0;
      chk("rgb",   i, 32'({red[i], grn[i], blu[i]}), 32'(want[23:0]));
      chk("valid", i, 32'(vld[i]), 32'(want[24]));
      chk("frame", i, act_fr(i), 32'(m_fr[i]));
      chk("busy",  i, 32'(bsy[i]), 32'(m_st[i] == 1));
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // --------------------------------------------------------------------------
  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    chk(nm, 0, got, want);
  endtask

  // Called at a negedge: drive, then advance to the next negedge.
  task automatic cyc(input logic t, input logic s);
    tick  = t;
    start = s;
    if (scan) begin
      hc = 11'(90 + (scan_n * 37) % 560);
      vc = 10'(45 + (scan_n * 13) % 540);
      scan_n++;
    end
    @(negedge clk);
  endtask

  task automatic hold(input int h, input int v);
    hc = 11'(h);
    vc = 10'(v);
    repeat (5) cyc(1'b0, 1'b0);
  endtask

  initial begin
    int pp[7];
    pp = '{1, 2, 3, 2, 1, 0, 1};
    rst_n = 1'b0; hc = 11'd100; vc = 10'd50; x = 11'd100; y = 10'd50;
    tick = 1'b0; start = 1'b0; mode = 2'd0; sel = 3'd0;
    repeat (3) @(negedge clk);
    lit("reset_rgb",   32'({red[0], grn[0], blu[0]}), 32'h0);
    lit("reset_valid", 32'(vld[0]), 32'h0);
    lit("reset_frame", 32'(fa), 32'h0);
    lit("reset_busy",  32'(bsy[0]), 32'h0);

    // Exact 4-cycle latency from reset release at hcount = x.
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);
    lit("lat3_valid", 32'(vld[0]), 32'h0);
    cyc(1'b0, 1'b0);
    lit("lat4_valid", 32'(vld[0]), 32'h1);
    lit("lat4_rgb_a", 32'({red[0], grn[0], blu[0]}), 32'h01FE10);
    lit("lat4_rgb_b", 32'({red[1], grn[1], blu[1]}), 32'h01FE10);

    // Geometry, scaling and transparency.
    hold(101, 50);
    lit("x1_rgb_a",   32'({red[0], grn[0], blu[0]}), 32'h02FD20);
    lit("x1_rgb_b",   32'({red[1], grn[1], blu[1]}), 32'h01FE10);
    hold(355, 50);
    lit("transp_valid_a", 32'(vld[0]), 32'h0);
    lit("transp_rgb_a",   32'({red[0], grn[0], blu[0]}), 32'h0);
    lit("col127_rgb_b",   32'({red[1], grn[1], blu[1]}), 32'h807F08);
    hold(356, 50);
    lit("right_out_a", 32'(vld[0]), 32'h0);
    hold(99, 50);
    lit("left_out_a",  32'(vld[0]), 32'h0);
    hold(611, 52);
    lit("edge_in_b",   32'({red[1], grn[1], blu[1]}), 32'h03FC30);
    hold(612, 52);
    lit("edge_out_b",  32'({vld[1], red[1], grn[1], blu[1]}), 32'h0);
    hold(100, 561);
    lit("bottom_in_b", 32'({red[1], grn[1], blu[1]}), 32'hFE01EF);
    hold(100, 562);
    lit("bottom_out_b", 32'({vld[1], red[1], grn[1], blu[1]}), 32'h0);

    // Ticks while idle are ignored.
    scan = 1;
    repeat (3) cyc(1'b1, 1'b0);
    lit("idle_frame", 32'(fa), 32'h0);

    // LOOP from frame 2, two ticks per step on u_a.
    mode = 2'd1; sel = 3'd2;
    cyc(1'b0, 1'b1);
    lit("loop_start", 32'(fa), 32'h2);
    lit("loop_busy",  32'(bsy[0]), 32'h1);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      if (k == 2) lit("loop_t2", 32'(fa), 32'h3);
      if (k == 4) lit("loop_t4", 32'(fa), 32'h0);
      if (k == 6) lit("loop_t6", 32'(fa), 32'h1);
    end

    // PINGPONG from 0, one tick per step on u_b.
    mode = 2'd3; sel = 3'd0;
    cyc(1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1, 1'b0);
      lit("pingpong", 32'(fb), 32'(pp[k]));
    end

    // ONESHOT from 2 on u_b.
    mode = 2'd2; sel = 3'd2;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    lit("oneshot_frame", 32'(fb), 32'h3);
    lit("oneshot_busy",  32'(bsy[1]), 32'h0);
    cyc(1'b1, 1'b0);
    lit("oneshot_held",  32'(fb), 32'h3);

    // start with tick in the same cycle, out-of-range select.
    mode = 2'd1; sel = 3'd7;
    cyc(1'b1, 1'b1);
    lit("clamp_a", 32'(fa), 32'h3);
    lit("clamp_c", 32'(fc), 32'h4);
    lit("clamp_d", 32'(fd), 32'h0);
    cyc(1'b1, 1'b0);
    lit("cnt0_a", 32'(fa), 32'h3);
    cyc(1'b1, 1'b0);
    lit("step_a", 32'(fa), 32'h0);
    cyc(1'b1, 1'b0);
    lit("wrap_c", 32'(fc), 32'h0);

    // HOLD keeps the selected frame and stays busy.
    mode = 2'd0; sel = 3'd1;
    cyc(1'b0, 1'b1);
    repeat (4) cyc(1'b1, 1'b0);
    lit("hold_frame", 32'(fa), 32'h1);
    lit("hold_busy",  32'(bsy[0]), 32'h1);

    // Reset in the middle of a running sequence.
    mode = 2'd1; sel = 3'd1;
    cyc(1'b0, 1'b1);
    repeat (5) cyc(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    lit("midrst_frame", 32'(fa), 32'h0);
    lit("midrst_busy",  32'(bsy[0]), 32'h0);
    lit("midrst_rgb",   32'({vld[0], red[0], grn[0], blu[0]}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) cyc(1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0);
    lit("post_rst_frame", 32'(fa), 32'h0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
